// File: rtl/watch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : watch_pkg                                                      |
// | Brief   : Shared encodings, limits and field helpers for the watch setter|
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package watch_pkg;

    typedef logic [6:0] tfield_t;

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_SET_TIME  = 3'd1,
        ST_SET_ALARM = 3'd2
    } state_t;

    typedef enum logic [1:0] {
        FLD_HOUR = 2'd0,
        FLD_MIN  = 2'd1,
        FLD_SEC  = 2'd2
    } field_t;

    localparam tfield_t HOUR_MAX   = 7'd23;
    localparam tfield_t MINSEC_MAX = 7'd59;

    function automatic tfield_t clamp_load(input tfield_t v, input tfield_t max_v);
        return (v > max_v) ? '0 : v;
    endfunction

    // Out-of-range values (only possible from a corrupt load) snap to a legal edge.
    function automatic tfield_t step_wrap(input tfield_t v, input tfield_t max_v, input logic up);
        tfield_t r;
        if (up)
            r = (v >= max_v) ? '0 : v + 7'd1;
        else
            r = (v == '0 || v > max_v) ? max_v : v - 7'd1;
        return r;
    endfunction

    function automatic field_t next_field(input field_t f, input logic alarm_mode);
        field_t r;
        if (alarm_mode) begin
            r = (f == FLD_HOUR) ? FLD_MIN : FLD_HOUR;
        end else begin
            case (f)
                FLD_HOUR: r = FLD_MIN;
                FLD_MIN : r = FLD_SEC;
                default : r = FLD_HOUR;
            endcase
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : key_debounce                                                   |
// | Brief   : 2-FF synchroniser, level debouncer and press-pulse generator   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 200
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic key_raw,
    output logic key_level,
    output logic key_press
);

    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_press;
    logic [c_CNT_W-1:0] r_cnt;

    // The counter measures how long the synchronised input has disagreed with
    // the accepted level; any return to the old level restarts it.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= key_raw;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_cnt == c_CNT_LAST) begin
                    r_level <= r_sync2;
                    r_press <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign key_level = r_level;
    assign key_press = r_press;

endmodule
`default_nettype wire

// File: rtl/watch_time_setter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : watch_time_setter                                              |
// | Brief   : Button-driven time/alarm setting FSM for the watch counter.    |
// |           Define WATCH_SET_AUTOREPEAT_EN for held UP/DOWN auto-repeat.   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module watch_time_setter
    import watch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 200,
    parameter int TIMEOUT_CYCLES  = 300000,
    parameter int BLINK_HALF      = 5000
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       KEY_MODE,
    input  logic       KEY_NEXT,
    input  logic       KEY_UP,
    input  logic       KEY_DOWN,
    input  logic       KEY_OK,
    input  logic [6:0] CUR_HOUR,
    input  logic [6:0] CUR_MIN,
    input  logic [6:0] CUR_SEC,
    output logic [6:0] SET_HOUR,
    output logic [6:0] SET_MIN,
    output logic [6:0] SET_SEC,
    output logic [2:0] STATE,
    output logic       OK,
    output logic [1:0] EDIT_FIELD,
    output logic       BLINK,
    output logic [6:0] ALARM_HOUR,
    output logic [6:0] ALARM_MIN,
    output logic       ALARM_EN
);

    localparam int c_TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int c_BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_BLK_W-1:0] c_BLK_LAST = c_BLK_W'(BLINK_HALF - 1);

    localparam int c_K_MODE = 0;
    localparam int c_K_NEXT = 1;
    localparam int c_K_UP   = 2;
    localparam int c_K_DOWN = 3;
    localparam int c_K_OK   = 4;

    logic [4:0] w_raw;
    logic [4:0] w_lvl;
    logic [4:0] w_pls;

    assign w_raw = {KEY_OK, KEY_DOWN, KEY_UP, KEY_NEXT, KEY_MODE};

    for (genvar gi = 0; gi < 5; gi++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key_debounce (
            .CLK      (CLK),
            .RESETN   (RESETN),
            .key_raw  (w_raw[gi]),
            .key_level(w_lvl[gi]),
            .key_press(w_pls[gi])
        );
    end

    logic w_rep_up;
    logic w_rep_dn;
    logic w_unused_lvl;

`ifdef WATCH_SET_AUTOREPEAT_EN
    localparam logic [12:0] c_REP_FIRST = 13'd4999;
    localparam logic [12:0] c_REP_NEXT  = 13'd999;

    logic [12:0] r_rep_cnt;
    logic        r_rep_armed;
    logic        w_rep_held;
    logic        w_rep_fire;

    assign w_rep_held = w_lvl[c_K_UP] | w_lvl[c_K_DOWN];
    assign w_rep_fire = w_rep_held && !(w_pls[c_K_UP] | w_pls[c_K_DOWN]) &&
                        (r_rep_cnt == (r_rep_armed ? c_REP_NEXT : c_REP_FIRST));
    assign w_rep_up   = w_rep_fire & w_lvl[c_K_UP];
    assign w_rep_dn   = w_rep_fire & ~w_lvl[c_K_UP] & w_lvl[c_K_DOWN];
    assign w_unused_lvl = ^{w_lvl[c_K_OK], w_lvl[c_K_NEXT], w_lvl[c_K_MODE]};

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
        end else if (!w_rep_held || w_pls[c_K_UP] || w_pls[c_K_DOWN]) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
        end else if (w_rep_fire) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b1;
        end else begin
            r_rep_cnt <= r_rep_cnt + 13'd1;
        end
    end
`else
    assign w_rep_up     = 1'b0;
    assign w_rep_dn     = 1'b0;
    assign w_unused_lvl = ^w_lvl;
`endif

    // Fixed priority OK > MODE > NEXT > UP > DOWN; losers are dropped.
    logic w_up_src, w_dn_src, w_key_any;
    logic w_ev_ok, w_ev_mode, w_ev_next, w_ev_up, w_ev_dn;

    assign w_up_src  = w_pls[c_K_UP] | w_rep_up;
    assign w_dn_src  = w_pls[c_K_DOWN] | w_rep_dn;
    assign w_key_any = (|w_pls) | w_rep_up | w_rep_dn;
    assign w_ev_ok   = w_pls[c_K_OK];
    assign w_ev_mode = w_pls[c_K_MODE] & ~w_ev_ok;
    assign w_ev_next = w_pls[c_K_NEXT] & ~(w_ev_ok | w_pls[c_K_MODE]);
    assign w_ev_up   = w_up_src & ~(w_ev_ok | w_pls[c_K_MODE] | w_pls[c_K_NEXT]);
    assign w_ev_dn   = w_dn_src & ~(w_ev_ok | w_pls[c_K_MODE] | w_pls[c_K_NEXT] | w_up_src);

    state_t             r_state;
    field_t             r_field;
    tfield_t            r_set_hour, r_set_min, r_set_sec;
    tfield_t            r_alarm_hour, r_alarm_min;
    logic               r_alarm_en;
    logic               r_ok;
    logic               r_blink;
    logic [c_TO_W-1:0]  r_to_cnt;
    logic [c_BLK_W-1:0] r_blk_cnt;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_state      <= ST_RUN;
            r_field      <= FLD_HOUR;
            r_set_hour   <= '0;
            r_set_min    <= '0;
            r_set_sec    <= '0;
            r_alarm_hour <= '0;
            r_alarm_min  <= '0;
            r_alarm_en   <= 1'b0;
            r_ok         <= 1'b0;
            r_blink      <= 1'b0;
            r_to_cnt     <= '0;
            r_blk_cnt    <= '0;
        end else if (r_ok) begin
            // Commit cycle: counter consumed SET_* while STATE was still SET_TIME.
            r_ok      <= 1'b0;
            r_state   <= ST_RUN;
            r_blink   <= 1'b0;
            r_to_cnt  <= '0;
            r_blk_cnt <= '0;
        end else begin
            case (r_state)
                ST_SET_TIME, ST_SET_ALARM: begin
                    r_to_cnt <= w_key_any ? '0 : r_to_cnt + c_TO_W'(1);
                    if (w_ev_up || w_ev_dn) begin
                        r_blink   <= 1'b1;
                        r_blk_cnt <= '0;
                    end else if (r_blk_cnt == c_BLK_LAST) begin
                        r_blink   <= ~r_blink;
                        r_blk_cnt <= '0;
                    end else begin
                        r_blk_cnt <= r_blk_cnt + c_BLK_W'(1);
                    end

                    if (w_ev_ok) begin
                        if (r_state == ST_SET_TIME) begin
                            r_ok <= 1'b1;
                        end else begin
                            r_alarm_hour <= r_set_hour;
                            r_alarm_min  <= r_set_min;
                            r_alarm_en   <= 1'b1;
                            r_state      <= ST_RUN;
                            r_blink      <= 1'b0;
                        end
                    end else if (w_ev_mode) begin
                        if (r_state == ST_SET_TIME) begin
                            r_state    <= ST_SET_ALARM;
                            r_set_hour <= r_alarm_hour;
                            r_set_min  <= r_alarm_min;
                            r_set_sec  <= '0;
                            r_field    <= FLD_HOUR;
                            r_blink    <= 1'b1;
                            r_blk_cnt  <= '0;
                        end else begin
                            r_state <= ST_RUN;
                            r_blink <= 1'b0;
                        end
                    end else if (w_ev_next) begin
                        r_field <= next_field(r_field, r_state == ST_SET_ALARM);
                    end else if (w_ev_up || w_ev_dn) begin
                        case (r_field)
                            FLD_HOUR: r_set_hour <= step_wrap(r_set_hour, HOUR_MAX, w_ev_up);
                            FLD_MIN : r_set_min  <= step_wrap(r_set_min, MINSEC_MAX, w_ev_up);
                            default : r_set_sec  <= step_wrap(r_set_sec, MINSEC_MAX, w_ev_up);
                        endcase
                    end else if (r_to_cnt == c_TO_LAST) begin
                        r_state <= ST_RUN;
                        r_blink <= 1'b0;
                    end
                end
                default: begin
                    r_to_cnt  <= '0;
                    r_blk_cnt <= '0;
                    r_blink   <= 1'b0;
                    if (w_ev_mode) begin
                        r_state    <= ST_SET_TIME;
                        r_set_hour <= clamp_load(CUR_HOUR, HOUR_MAX);
                        r_set_min  <= clamp_load(CUR_MIN, MINSEC_MAX);
                        r_set_sec  <= clamp_load(CUR_SEC, MINSEC_MAX);
                        r_field    <= FLD_HOUR;
                        r_blink    <= 1'b1;
                    end else if (w_ev_ok) begin
                        r_alarm_en <= ~r_alarm_en;
                    end
                end
            endcase
        end
    end

    assign SET_HOUR   = r_set_hour;
    assign SET_MIN    = r_set_min;
    assign SET_SEC    = r_set_sec;
    assign STATE      = r_state;
    assign OK         = r_ok;
    assign EDIT_FIELD = r_field;
    assign BLINK      = r_blink;
    assign ALARM_HOUR = r_alarm_hour;
    assign ALARM_MIN  = r_alarm_min;
    assign ALARM_EN   = r_alarm_en;

endmodule
`default_nettype wire

// File: tb/tb_watch_time_setter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_watch_time_setter                                           |
// | Brief   : Scoreboard-based self-checking bench for watch_time_setter     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_watch_time_setter;

    localparam int DB  = 200;
    localparam int TO  = 3000;
    localparam int BLK = 50;

    localparam logic [4:0] M_MODE = 5'b00001;
    localparam logic [4:0] M_NEXT = 5'b00010;
    localparam logic [4:0] M_UP   = 5'b00100;
    localparam logic [4:0] M_DOWN = 5'b01000;
    localparam logic [4:0] M_OK   = 5'b10000;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic [4:0] keys = '0;
    logic [6:0] cur_h = '0, cur_m = '0, cur_s = '0;
    logic [6:0] set_h, set_m, set_s, al_h, al_m;
    logic [2:0] state;
    logic [1:0] field;
    logic       ok, blink, al_en;

    watch_time_setter #(
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES (TO),
        .BLINK_HALF     (BLK)
    ) dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .KEY_MODE  (keys[0]),
        .KEY_NEXT  (keys[1]),
        .KEY_UP    (keys[2]),
        .KEY_DOWN  (keys[3]),
        .KEY_OK    (keys[4]),
        .CUR_HOUR  (cur_h),
        .CUR_MIN   (cur_m),
        .CUR_SEC   (cur_s),
        .SET_HOUR  (set_h),
        .SET_MIN   (set_m),
        .SET_SEC   (set_s),
        .STATE     (state),
        .OK        (ok),
        .EDIT_FIELD(field),
        .BLINK     (blink),
        .ALARM_HOUR(al_h),
        .ALARM_MIN (al_m),
        .ALARM_EN  (al_en)
    );

    always #5 CLK = ~CLK;

    logic [41:0] obs;
    assign obs = {state, set_h, set_m, set_s, field, al_h, al_m, al_en, ok};

    logic [41:0] sb[$];
    logic [41:0] exp_v;
    int n_checks = 0;
    int n_errors = 0;
    int ok_cnt = 0;
    int ok_bad = 0;

    always @(negedge CLK) begin
        if (RESETN && ok === 1'b1) begin
            ok_cnt++;
            if (state !== 3'd1) ok_bad++;
        end
    end

    function automatic logic [41:0] pack(input int st, input int h, input int m, input int s,
                                         input int f, input int ah, input int am,
                                         input int en, input int k);
        return {3'(st), 7'(h), 7'(m), 7'(s), 2'(f), 7'(ah), 7'(am), 1'(en), 1'(k)};
    endfunction

    // Each helper ends 1 time unit after a rising edge.
    task automatic press_hold(input logic [4:0] mask);
        keys = keys | mask;
        repeat (DB + 3) @(posedge CLK);
        #1;
    endtask

    task automatic release_keys();
        keys = '0;
        repeat (DB + 5) @(posedge CLK);
        #1;
    endtask

    task automatic press(input logic [4:0] mask);
        press_hold(mask);
        release_keys();
    endtask

    task automatic test_reset();
        RESETN = 1'b0;
        cur_h = 7'd12; cur_m = 7'd34; cur_s = 7'd56;
        repeat (3) @(posedge CLK);
        #1;
        sb.push_back(pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_v = sb.pop_front(); n_checks++;
        if (obs !== exp_v || blink !== 1'b0) begin
            n_errors++; $display("FAIL reset: got %h blink %b want %h blink 0", obs, blink, exp_v);
        end
        RESETN = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_enter_set();
        sb.push_back(pack(1, 12, 34, 56, 0, 0, 0, 0, 0));
        press(M_MODE);
        exp_v = sb.pop_front(); n_checks++;
        if (obs !== exp_v) begin
            n_errors++; $display("FAIL enter_set: got %h want %h", obs, exp_v);
        end
        n_checks++;
        if (ok_cnt !== 0) begin
            n_errors++; $display("FAIL enter_set_ok: got %0d ok cycles want 0", ok_cnt);
        end
    endtask

    task automatic test_wrap();
        press(M_MODE);
        press(M_MODE);
        cur_h = 7'd23; cur_m = 7'd0; cur_s = 7'd0;
        press(M_MODE);
        sb.push_back(pack(1, 0, 0, 0, 0, 0, 0, 0, 0));
        press_hold(M_UP);
        exp_v = sb.pop_front(); n_checks++;
        if (obs !== exp_v || blink !== 1'b1) begin
            n_errors++; $display("FAIL hour_wrap: got %h blink %b want %h blink 1", obs, blink, exp_v);
        end
        repeat (25) @(posedge CLK);
        #1; n_checks++;
        if (blink !== 1'b1) begin
            n_errors++; $display("FAIL blink_hold: got %b want 1", blink);
        end
        repeat (50) @(posedge CLK);
        #1; n_checks++;
        if (blink !== 1'b0) begin
            n_errors++; $display("FAIL blink_toggle: got %b want 0", blink);
        end
        release_keys();
        press(M_NEXT);
        sb.push_back(pack(1, 0, 59, 0, 1, 0, 0, 0, 0));
        press(M_DOWN);
        exp_v = sb.pop_front(); n_checks++;
        if (obs !== exp_v) begin
            n_errors++; $display("FAIL min_wrap: got %h want %h", obs, exp_v);
        end
        press(M_NEXT);
        n_checks++;
        if (field !== 2'd2) begin
            n_errors++; $display("FAIL field_sec: got %0d want 2", field);
        end
        sb.push_back(pack(1, 0, 59, 0, 0, 0, 0, 0, 0));
        press(M_NEXT);
        exp_v = sb.pop_front(); n_checks++;
        if (obs !== exp_v) begin
            n_errors++; $display("FAIL field_cycle: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_commit();
        press(M_MODE);
        press(M_MODE);
        cur_h = 7'd7; cur_m = 7'd5; cur_s = 7'd9;
        press(M_MODE);
        sb.push_back(pack(1, 7, 5, 9, 0, 0, 0, 0, 1));
        sb.push_back(pack(0, 7, 5, 9, 0, 0, 0, 0, 0));
        press_hold(M_OK);
        exp_v = sb.pop_front(); n_checks++;
        if (obs !== exp_v) begin
            n_errors++; $display("FAIL commit_pulse: got %h want %h", obs, exp_v);
        end
        @(posedge CLK); #1;
        exp_v = sb.pop_front(); n_checks++;
        if (obs !== exp_v || blink !== 1'b0) begin
            n_errors++; $display("FAIL commit_after: got %h blink %b want %h blink 0", obs, blink, exp_v);
        end
        release_keys();
        n_checks++;
        if (ok_cnt !== 1) begin
            n_errors++; $display("FAIL commit_len: got %0d ok cycles want 1", ok_cnt);
        end
    endtask

    task automatic test_alarm();
        press(M_MODE);
        sb.push_back(pack(2, 0, 0, 0, 0, 0, 0, 0, 0));
        press(M_MODE);
        exp_v = sb.pop_front(); n_checks++;
        if (obs !== exp_v) begin
            n_errors++; $display("FAIL alarm_enter: got %h want %h", obs, exp_v);
        end
        for (int i = 0; i < 6; i++) press(M_UP);
        press(M_NEXT);
        for (int i = 0; i < 30; i++) press(M_UP);
        press(M_NEXT);
        n_checks++;
        if (field !== 2'd0) begin
            n_errors++; $display("FAIL alarm_field: got %0d want 0", field);
        end
        sb.push_back(pack(0, 6, 30, 0, 0, 6, 30, 1, 0));
        press(M_OK);
        exp_v = sb.pop_front(); n_checks++;
        if (obs !== exp_v || ok_cnt !== 1) begin
            n_errors++; $display("FAIL alarm_commit: got %h ok %0d want %h ok 1", obs, ok_cnt, exp_v);
        end
        sb.push_back(pack(0, 6, 30, 0, 0, 6, 30, 0, 0));
        press(M_OK);
        exp_v = sb.pop_front(); n_checks++;
        if (obs !== exp_v) begin
            n_errors++; $display("FAIL alarm_toggle: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_bounce();
        cur_h = 7'd10; cur_m = 7'd20; cur_s = 7'd30;
        press(M_MODE);
        sb.push_back(pack(1, 11, 20, 30, 0, 6, 30, 0, 0));
        for (int i = 0; i < 20; i++) begin
            keys[2] = ~keys[2];
            repeat (50) @(posedge CLK);
            #1;
        end
        keys[2] = 1'b1;
        repeat (250) @(posedge CLK);
        #1;
        release_keys();
        exp_v = sb.pop_front(); n_checks++;
        if (obs !== exp_v) begin
            n_errors++; $display("FAIL bounce: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        sb.push_back(pack(1, 11, 20, 30, 0, 6, 30, 0, 1));
        sb.push_back(pack(0, 11, 20, 30, 0, 6, 30, 0, 0));
        press_hold(M_UP | M_OK);
        exp_v = sb.pop_front(); n_checks++;
        if (obs !== exp_v) begin
            n_errors++; $display("FAIL up_ok_same: got %h want %h", obs, exp_v);
        end
        @(posedge CLK); #1;
        exp_v = sb.pop_front(); n_checks++;
        if (obs !== exp_v) begin
            n_errors++; $display("FAIL up_ok_after: got %h want %h", obs, exp_v);
        end
        release_keys();
    endtask

    task automatic test_clamp_timeout();
        cur_h = 7'd24; cur_m = 7'd59; cur_s = 7'd60;
        sb.push_back(pack(1, 0, 59, 0, 0, 6, 30, 0, 0));
        sb.push_back(pack(0, 0, 59, 0, 0, 6, 30, 0, 0));
        press(M_MODE);
        exp_v = sb.pop_front(); n_checks++;
        if (obs !== exp_v) begin
            n_errors++; $display("FAIL cur_clamp: got %h want %h", obs, exp_v);
        end
        repeat (TO - DB - 105) @(posedge CLK);
        #1; n_checks++;
        if (state !== 3'd1) begin
            n_errors++; $display("FAIL pre_timeout: got state %0d want 1", state);
        end
        repeat (200) @(posedge CLK);
        #1;
        exp_v = sb.pop_front(); n_checks++;
        if (obs !== exp_v || ok_cnt !== 2) begin
            n_errors++; $display("FAIL timeout: got %h ok %0d want %h ok 2", obs, ok_cnt, exp_v);
        end
    endtask

    task automatic test_reset_mid();
        press(M_MODE);
        press(M_UP);
        n_checks++;
        if (set_h !== 7'd1) begin
            n_errors++; $display("FAIL mid_edit: got hour %0d want 1", set_h);
        end
        sb.push_back(pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
        keys = M_OK;
        RESETN = 1'b0;
        @(posedge CLK); #1;
        exp_v = sb.pop_front(); n_checks++;
        if (obs !== exp_v || blink !== 1'b0) begin
            n_errors++; $display("FAIL reset_mid: got %h blink %b want %h blink 0", obs, blink, exp_v);
        end
        keys = '0;
        repeat (2) @(posedge CLK);
        #1;
        RESETN = 1'b1;
        n_checks++;
        if (ok_bad !== 0) begin
            n_errors++; $display("FAIL ok_state: got %0d OK cycles outside STATE 1 want 0", ok_bad);
        end
    endtask

    initial begin
        test_reset();
        test_enter_set();
        test_wrap();
        test_commit();
        test_alarm();
        test_bounce();
        test_back_to_back();
        test_clamp_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
